fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decoder.
- Owns the fetch PC and the instruction-memory request handshake.
- Latches the fetched word into IR for the decoder, including a one-entry skid buffer.
- Consumes the decoder's PCsel/PCvector/PCoffset/PCjump to form the next fetch address, honouring the MIPS one-instruction branch delay slot.

---
 rtl/fetch_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, the I-memory request handshake,
// IR plus a one-entry skid buffer, and MIPS delay-slot redirects.
// Optional: define FETCH_ALIGN_CHECK_EN to trap misaligned register targets.

`ifndef SELECT_PC_INC
`define SELECT_PC_INC      5'd0
`endif
`ifndef SELECT_PC_ADD
`define SELECT_PC_ADD      5'd1
`endif
`ifndef SELECT_PC_JUMP
`define SELECT_PC_JUMP     5'd2
`endif
`ifndef SELECT_PC_REGISTER
`define SELECT_PC_REGISTER 5'd3
`endif
`ifndef SELECT_PC_VECTOR
`define SELECT_PC_VECTOR   5'd4
`endif
`ifndef INIT_VECTOR
`define INIT_VECTOR        32'hBFC0_0000
`endif

module fetch_unit (
    input  logic        CLK,
    input  logic        MRST,
    input  logic [4:0]  PCsel,
    input  logic [31:0] PCvector,
    input  logic [31:0] PCoffset,
    input  logic [25:0] PCjump,
    input  logic [31:0] RSdata,
    input  logic        Stall,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IAck,
    input  logic [31:0] IData,
    output logic [31:0] IR,
    output logic        IRvalid,
    output logic [31:0] PC,
    output logic [31:0] PCinc,
    output logic        AlignErr
);

    typedef enum logic [1:0] {BOOT, REQ, SKID} state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic        redir_v, redir_v_nx;
    logic [31:0] redir_t, redir_t_nx;
    logic        req_q, req_nx;
    logic        discard, discard_nx;
    logic [31:0] stale_addr, stale_addr_nx;
    logic [31:0] ir_q, ir_nx;
    logic [31:0] pc_q, pc_nx;
    logic        irv_q, irv_nx;
    logic [31:0] skid_ir, skid_ir_nx;
    logic [31:0] skid_pc, skid_pc_nx;

    logic        consume;
    logic        ack;
    logic        redirect;
    logic        vector_sel;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign consume = irv_q & ~Stall;
    assign ack     = req_q & IAck;
    assign pc_inc  = pc_q + 32'd4;

    assign IReq    = req_q;
    // A request abandoned by a vector keeps its original address until acked.
    assign IAddr   = discard ? stale_addr : fetch_pc;
    assign IR      = ir_q;
    assign IRvalid = irv_q;
    assign PC      = pc_q;
    assign PCinc   = pc_inc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_hit;
    logic align_q;
    assign AlignErr = align_q;
`else
    assign AlignErr = 1'b0;
`endif

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        redirect   = 1'b0;
        vector_sel = 1'b0;
        target     = pc_inc;
`ifdef FETCH_ALIGN_CHECK_EN
        align_hit  = 1'b0;
`endif
        case (PCsel)
            `SELECT_PC_INC: ;
            `SELECT_PC_ADD: begin
                redirect = 1'b1;
                target   = pc_inc + PCoffset;
            end
            `SELECT_PC_JUMP: begin
                redirect = 1'b1;
                target   = {pc_inc[31:28], PCjump, 2'b00};
            end
            `SELECT_PC_REGISTER: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (RSdata[1:0] != 2'b00) begin
                    vector_sel = 1'b1;
                    align_hit  = 1'b1;
                end else begin
                    redirect = 1'b1;
                    target   = RSdata;
                end
`else
                redirect = 1'b1;
                target   = RSdata & ~32'd3;
`endif
            end
            `SELECT_PC_VECTOR: vector_sel = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nx      = state;
        fetch_pc_nx   = fetch_pc;
        redir_v_nx    = redir_v;
        redir_t_nx    = redir_t;
        req_nx        = req_q;
        discard_nx    = discard;
        stale_addr_nx = stale_addr;
        ir_nx         = ir_q;
        pc_nx         = pc_q;
        irv_nx        = irv_q;
        skid_ir_nx    = skid_ir;
        skid_pc_nx    = skid_pc;

        case (state)
            BOOT: begin
                state_nx = REQ;
                req_nx   = 1'b1;
            end

            REQ: begin
                if (ack) begin
                    if (discard) begin
                        discard_nx = 1'b0;
                    end else begin
                        if (!irv_q || consume) begin
                            ir_nx  = IData;
                            pc_nx  = fetch_pc;
                            irv_nx = 1'b1;
                        end else begin
                            skid_ir_nx = IData;
                            skid_pc_nx = fetch_pc;
                            state_nx   = SKID;
                        end
                        if (redir_v) begin
                            fetch_pc_nx = redir_t;
                            redir_v_nx  = 1'b0;
                        end else begin
                            fetch_pc_nx = fetch_pc + 32'd4;
                        end
                    end
                end else if (consume) begin
                    irv_nx = 1'b0;
                end

                if (consume && redirect) begin
                    // The word arriving now is the delay slot, so skip the pending register.
                    if (ack && !discard) begin
                        fetch_pc_nx = target;
                    end else begin
                        redir_v_nx = 1'b1;
                        redir_t_nx = target;
                    end
                end

                if (consume && vector_sel) begin
                    fetch_pc_nx = PCvector;
                    redir_v_nx  = 1'b0;
                    irv_nx      = 1'b0;
                    state_nx    = REQ;
                    if (req_q && !IAck) begin
                        discard_nx    = 1'b1;
                        stale_addr_nx = IAddr;
                    end
                end

                // A request decided last cycle is held until acked, even if Stall rises.
                if (req_q && !IAck) begin
                    req_nx = 1'b1;
                end else begin
                    req_nx = (state_nx == REQ) && (!irv_q || consume);
                end
            end

            SKID: begin
                if (consume) begin
                    ir_nx    = skid_ir;
                    pc_nx    = skid_pc;
                    state_nx = REQ;
                    req_nx   = 1'b1;
                    if (vector_sel) begin
                        fetch_pc_nx = PCvector;
                        redir_v_nx  = 1'b0;
                        irv_nx      = 1'b0;
                    end else if (redirect) begin
                        // Delay slot is already in the skid, so the target is fetched next.
                        fetch_pc_nx = target;
                    end
                end
            end

            default: state_nx = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge MRST) begin
        if (MRST) begin
            state      <= BOOT;
            fetch_pc   <= `INIT_VECTOR;
            redir_v    <= 1'b0;
            redir_t    <= 32'd0;
            req_q      <= 1'b0;
            discard    <= 1'b0;
            stale_addr <= 32'd0;
            ir_q       <= 32'd0;
            pc_q       <= 32'd0;
            irv_q      <= 1'b0;
            skid_ir    <= 32'd0;
            skid_pc    <= 32'd0;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            redir_v    <= redir_v_nx;
            redir_t    <= redir_t_nx;
            req_q      <= req_nx;
            discard    <= discard_nx;
            stale_addr <= stale_addr_nx;
            ir_q       <= ir_nx;
            pc_q       <= pc_nx;
            irv_q      <= irv_nx;
            skid_ir    <= skid_ir_nx;
            skid_pc    <= skid_pc_nx;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge MRST) begin
        if (MRST) begin
            align_q <= 1'b0;
        end else begin
            align_q <= consume & align_hit;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/decoder model drives the inputs,
// a monitor checks every consumed instruction against the expected-PC queue.

`ifndef SELECT_PC_INC
`define SELECT_PC_INC      5'd0
`endif
`ifndef SELECT_PC_ADD
`define SELECT_PC_ADD      5'd1
`endif
`ifndef SELECT_PC_JUMP
`define SELECT_PC_JUMP     5'd2
`endif
`ifndef SELECT_PC_REGISTER
`define SELECT_PC_REGISTER 5'd3
`endif
`ifndef SELECT_PC_VECTOR
`define SELECT_PC_VECTOR   5'd4
`endif
`ifndef INIT_VECTOR
`define INIT_VECTOR        32'hBFC0_0000
`endif

module tb_fetch_unit;

    localparam logic [31:0] INIT       = `INIT_VECTOR;
    localparam logic [31:0] PARK       = 32'h0000_0F00;
    localparam logic [4:0]  SEL_INC    = `SELECT_PC_INC;
    localparam logic [4:0]  SEL_ADD    = `SELECT_PC_ADD;
    localparam logic [4:0]  SEL_JUMP   = `SELECT_PC_JUMP;
    localparam logic [4:0]  SEL_REG    = `SELECT_PC_REGISTER;
    localparam logic [4:0]  SEL_VECTOR = `SELECT_PC_VECTOR;

    logic        CLK = 1'b0;
    logic        MRST;
    logic [4:0]  PCsel;
    logic [31:0] PCvector;
    logic [31:0] PCoffset;
    logic [25:0] PCjump;
    logic [31:0] RSdata;
    logic        Stall;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IAck;
    logic [31:0] IData;
    logic [31:0] IR;
    logic        IRvalid;
    logic [31:0] PC;
    logic [31:0] PCinc;
    logic        AlignErr;

    fetch_unit dut (
        .CLK      (CLK),
        .MRST     (MRST),
        .PCsel    (PCsel),
        .PCvector (PCvector),
        .PCoffset (PCoffset),
        .PCjump   (PCjump),
        .RSdata   (RSdata),
        .Stall    (Stall),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IAck     (IAck),
        .IData    (IData),
        .IR       (IR),
        .IRvalid  (IRvalid),
        .PC       (PC),
        .PCinc    (PCinc),
        .AlignErr (AlignErr)
    );

    always #5 CLK = ~CLK;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          mem_wait    = 0;
    logic        force_ack   = 1'b0;
    logic [31:0] park_vec    = PARK;
    int          align_pulses = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d instructions never consumed, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        park_vec = PARK;
        repeat (4) @(posedge CLK);
    endtask

    // Memory responder and decoder model; both update on the falling edge.
    initial begin : mem_dec
        int wait_cnt;
        wait_cnt = 0;
        IAck = 1'b0;
        IData = 32'd0;
        PCsel = SEL_INC;
        PCvector = 32'd0;
        PCoffset = 32'd0;
        PCjump = 26'd0;
        RSdata = 32'd0;
        forever begin
            @(negedge CLK);
            IAck  = 1'b0;
            IData = 32'd0;
            if (force_ack) begin
                IAck     = 1'b1;
                IData    = 32'hDEAD_BEEF;
                wait_cnt = 0;
            end else if (IReq) begin
                if (wait_cnt >= mem_wait) begin
                    IAck     = 1'b1;
                    IData    = word_of(IAddr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end

            PCsel    = SEL_INC;
            PCoffset = 32'd0;
            PCjump   = 26'd0;
            RSdata   = 32'd0;
            PCvector = 32'hEEEE_0000;
            if (IRvalid) begin
                if (PC == INIT + 32'd8 || PC == 32'h124 || PC == 32'h410 ||
                    PC == 32'h300 || PC == 32'h600) begin
                    PCsel    = SEL_VECTOR;
                    PCvector = PARK;
                end else if (PC == PARK) begin
                    PCsel    = SEL_VECTOR;
                    PCvector = park_vec;
                end else if (PC == 32'h100) begin
                    PCsel    = SEL_ADD;
                    PCoffset = 32'h20;
                end else if (PC == 32'h200) begin
                    PCsel  = SEL_JUMP;
                    PCjump = 26'h40;
                end else if (PC == 32'h500) begin
                    PCsel    = SEL_REG;
                    RSdata   = 32'h303;
                    PCvector = 32'h600;
                end
            end
        end
    end

    // Pops one expected PC for every instruction the decoder consumes.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge CLK);
            if (AlignErr) align_pulses++;
            if (!MRST && IRvalid && !Stall && PC != PARK) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_instr: got PC %h, expected no instruction", PC);
                end else begin
                    e = exp_q.pop_front();
                    check("pc", PC, e);
                    check("ir", IR, word_of(e));
                    check("pcinc", PCinc, e + 32'd4);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int align_base;
        MRST  = 1'b1;
        Stall = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ireq", 32'(IReq), 32'd0);
        check("rst_irvalid", 32'(IRvalid), 32'd0);
        check("rst_ir", IR, 32'd0);
        check("rst_pc", PC, 32'd0);
        check("rst_pcinc", PCinc, 32'd4);
        check("rst_iaddr", IAddr, INIT);
        check("rst_alignerr", 32'(AlignErr), 32'd0);

        // Zero-wait boot: linear fetch from the reset vector.
        exp_q.push_back(INIT);
        exp_q.push_back(INIT + 32'd4);
        exp_q.push_back(INIT + 32'd8);
        MRST = 1'b0;
        @(negedge CLK);
        check("boot_ireq", 32'(IReq), 32'd0);
        @(negedge CLK);
        check("first_ireq", 32'(IReq), 32'd1);
        check("first_iaddr", IAddr, INIT);
        check("first_irvalid", 32'(IRvalid), 32'd0);
        @(negedge CLK);
        check("irvalid_rise", 32'(IRvalid), 32'd1);
        check("second_iaddr", IAddr, INIT + 32'd4);
        @(negedge CLK);
        check("third_iaddr", IAddr, INIT + 32'd8);
        wait_drain("boot_seq");

        // Taken BEQ at 0x100, delay slot arrives with the branch consume.
        mem_wait = 0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h124);
        park_vec = 32'h100;
        wait_drain("beq_seq");

        // JAL at 0x200 with one wait state, lands on the BEQ sequence.
        mem_wait = 1;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h124);
        park_vec = 32'h200;
        wait_drain("jal_seq");

        // Stall with a request already committed: IR and skid fill, IReq drops.
        mem_wait = 0;
        for (int a = 32'h400; a <= 32'h410; a += 4) exp_q.push_back(32'(a));
        park_vec = 32'h400;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!(IRvalid && PC == 32'h404) && n < 200);
        check("stall_entry_pc", PC, 32'h404);
        Stall = 1'b1;
        @(negedge CLK);
        check("stall_inflight_ireq", 32'(IReq), 32'd1);
        check("stall_inflight_iaddr", IAddr, 32'h408);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("skid_ireq", 32'(IReq), 32'd0);
            check("skid_hold_pc", PC, 32'h404);
            check("skid_hold_irvalid", 32'(IRvalid), 32'd1);
        end
        @(negedge CLK);
        @(posedge CLK);
        #1;
        Stall = 1'b0;
        wait_drain("stall_seq");

        // JR to a misaligned register target.
        mem_wait = 2;
        align_base = align_pulses;
        exp_q.push_back(32'h500);
`ifdef FETCH_ALIGN_CHECK_EN
        exp_q.push_back(32'h600);
`else
        exp_q.push_back(32'h504);
        exp_q.push_back(32'h300);
`endif
        park_vec = 32'h500;
        wait_drain("jr_seq");
`ifdef FETCH_ALIGN_CHECK_EN
        check("alignerr_pulses", 32'(align_pulses - align_base), 32'd1);
`else
        check("alignerr_pulses", 32'(align_pulses - align_base), 32'd0);
`endif

        // Reset in the middle of a slow request, with a stray acknowledge afterwards.
        mem_wait = 20;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!IReq && n < 100);
        @(negedge CLK);
        #1;
        MRST = 1'b1;
        #1;
        check("midrst_ireq", 32'(IReq), 32'd0);
        check("midrst_irvalid", 32'(IRvalid), 32'd0);
        check("midrst_iaddr", IAddr, INIT);
        check("midrst_pc", PC, 32'd0);
        check("midrst_pcinc", PCinc, 32'd4);
        check("midrst_ir", IR, 32'd0);
        force_ack = 1'b1;
        repeat (2) @(posedge CLK);
        mem_wait = 0;
        exp_q.push_back(INIT);
        exp_q.push_back(INIT + 32'd4);
        exp_q.push_back(INIT + 32'd8);
        #1;
        MRST = 1'b0;
        @(posedge CLK);
        #1;
        force_ack = 1'b0;
        check("late_ack_irvalid", 32'(IRvalid), 32'd0);
        @(negedge CLK);
        check("restart_iaddr", IAddr, INIT);
        wait_drain("restart_seq");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
